time_entry: RTL and testbench

TIME_ENTRY -- requirements
Module: time_entry

---
 rtl/time_entry.sv | 113 +++++++++++
 tb/tb_time_entry.sv | 138 +++++++++++++
 2 files changed

// File: rtl/time_entry.sv
// time_entry: keypad time-entry and countdown control for a four-digit BCD
// down-counter chain (MM:SS).
//
// Ports:
//   clk, clrn            clock, synchronous active-low reset
//   key_valid, key_code  one-cycle keypad strobe and key value (0-9 digits)
//   start, clear         one-cycle start / cancel commands
//   timer_zero           all downstream digit counters read zero
//   min_tens..sec_ones   BCD preset to the counters' data ports
//   loadn                active-low synchronous load to the counters
//   run_en               count enable to the counters
//   digit_cnt            digits entered so far, 0-4
//   done, err            one-cycle completion / rejection pulses
//
// Every output is a flop. loadn and run_en are decoded from the next state,
// so they line up exactly with the LOAD and RUN cycles.
module time_entry (
  input  logic       clk,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start,
  input  logic       clear,
  input  logic       timer_zero,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       loadn,
  output logic       run_en,
  output logic [2:0] digit_cnt,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t          state, state_nx;
  // dig[3]=min_tens ... dig[0]=sec_ones; entry shifts toward dig[3]
  logic [3:0][3:0] dig, dig_nx;
  logic [2:0]      cnt_nx;
  logic            done_nx, err_nx;
  logic            start_ok;

  assign min_tens = dig[3];
  assign min_ones = dig[2];
  assign sec_tens = dig[1];
  assign sec_ones = dig[0];

  // A start needs at least one digit, a nonzero time and a legal seconds tens.
  assign start_ok = (digit_cnt != 3'd0) && (dig != '0) && (dig[1] <= 4'd5);

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state     <= IDLE;
      dig       <= '0;
      digit_cnt <= 3'd0;
      loadn     <= 1'b1;
      run_en    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      dig       <= dig_nx;
      digit_cnt <= cnt_nx;
      loadn     <= (state_nx != LOAD);
      run_en    <= (state_nx == RUN);
      done      <= done_nx;
      err       <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    dig_nx   = dig;
    cnt_nx   = digit_cnt;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    if (clear) begin
      state_nx = IDLE;
      dig_nx   = '0;
      cnt_nx   = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          // start wins over a coincident key; the key is dropped silently
          if (start) begin
            if (start_ok) state_nx = LOAD;
            else          err_nx   = 1'b1;
          end else if (key_valid) begin
            if (key_code > 4'd9 || digit_cnt == 3'd4) begin
              err_nx = 1'b1;
            end else begin
              dig_nx = {dig[2:0], key_code};
              cnt_nx = digit_cnt + 3'd1;
            end
          end
        end
        LOAD: state_nx = RUN;
        RUN: begin
          if (timer_zero) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
            dig_nx   = '0;
            cnt_nx   = 3'd0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_time_entry.sv
module tb_time_entry;

  logic       clk = 1'b0;
  logic       clrn, key_valid, start, clear, timer_zero;
  logic [3:0] key_code;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       loadn, run_en, done, err;
  logic [2:0] digit_cnt;

  int checks = 0;
  int errors = 0;

  time_entry dut (
    .clk(clk), .clrn(clrn), .key_valid(key_valid), .key_code(key_code),
    .start(start), .clear(clear), .timer_zero(timer_zero),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .loadn(loadn), .run_en(run_en), .digit_cnt(digit_cnt), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // ctl = {loadn, run_en, done, err}; dig = {min_tens, min_ones, sec_tens, sec_ones}
  wire [3:0]  ctl = {loadn, run_en, done, err};
  wire [15:0] dig = {min_tens, min_ones, sec_tens, sec_ones};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1; key_code = k;
    tick();
    key_valid = 1'b0; key_code = 4'd0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_reset();
    clrn = 1'b0; tick();
    checks++; if (ctl !== 4'b1000) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, 4'b1000); end
    checks++; if (dig !== 16'h0000 || digit_cnt !== 3'd0) begin errors++; $display("FAIL reset_dig got %h/%0d exp 0000/0", dig, digit_cnt); end
    clrn = 1'b1; tick();
  endtask

  task automatic test_entry_run();
    press(4'd1); press(4'd3); press(4'd0);
    checks++; if (dig !== 16'h0130 || digit_cnt !== 3'd3) begin errors++; $display("FAIL entry_dig got %h/%0d exp 0130/3", dig, digit_cnt); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL load_ctl got %b exp %b", ctl, 4'b0000); end
    tick();
    checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL run_ctl got %b exp %b", ctl, 4'b1100); end
    tick();
    checks++; if (ctl !== 4'b1100 || dig !== 16'h0130) begin errors++; $display("FAIL run_hold got %b/%h exp 1100/0130", ctl, dig); end
    timer_zero = 1'b1; tick(); timer_zero = 1'b0;
    checks++; if (ctl !== 4'b1010) begin errors++; $display("FAIL done_ctl got %b exp %b", ctl, 4'b1010); end
    checks++; if (dig !== 16'h0000 || digit_cnt !== 3'd0) begin errors++; $display("FAIL done_dig got %h/%0d exp 0000/0", dig, digit_cnt); end
    tick();
    checks++; if (ctl !== 4'b1000) begin errors++; $display("FAIL done_idle got %b exp %b", ctl, 4'b1000); end
  endtask

  task automatic test_overflow();
    do_clear();
    press(4'd5); press(4'd9); press(4'd5); press(4'd9);
    checks++; if (dig !== 16'h5959 || digit_cnt !== 3'd4 || err !== 1'b0) begin errors++; $display("FAIL ovf_fill got %h/%0d/%b exp 5959/4/0", dig, digit_cnt, err); end
    press(4'd7);
    checks++; if (ctl !== 4'b1001 || dig !== 16'h5959 || digit_cnt !== 3'd4) begin errors++; $display("FAIL ovf_err got %b/%h/%0d exp 1001/5959/4", ctl, dig, digit_cnt); end
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovf_pulse got %b exp 0", err); end
  endtask

  task automatic test_invalid_key();
    do_clear();
    checks++; if (dig !== 16'h0000 || digit_cnt !== 3'd0) begin errors++; $display("FAIL clear_idle got %h/%0d exp 0000/0", dig, digit_cnt); end
    press(4'd3); press(4'd12);
    checks++; if (ctl !== 4'b1001 || dig !== 16'h0003 || digit_cnt !== 3'd1) begin errors++; $display("FAIL badkey got %b/%h/%0d exp 1001/0003/1", ctl, dig, digit_cnt); end
  endtask

  task automatic test_bad_start();
    do_clear();
    press(4'd1); press(4'd7); press(4'd5);
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (ctl !== 4'b1001 || dig !== 16'h0175 || digit_cnt !== 3'd3) begin errors++; $display("FAIL sec_tens got %b/%h/%0d exp 1001/0175/3", ctl, dig, digit_cnt); end
    tick();
    checks++; if (ctl !== 4'b1000) begin errors++; $display("FAIL sec_tens_idle got %b exp %b", ctl, 4'b1000); end
    do_clear();
    press(4'd0);
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (ctl !== 4'b1001 || digit_cnt !== 3'd1) begin errors++; $display("FAIL zero_start got %b/%0d exp 1001/1", ctl, digit_cnt); end
    do_clear();
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (ctl !== 4'b1001) begin errors++; $display("FAIL empty_start got %b exp %b", ctl, 4'b1001); end
  endtask

  task automatic test_coincide_and_run();
    do_clear();
    press(4'd2);
    key_valid = 1'b1; key_code = 4'd4; start = 1'b1; tick();
    key_valid = 1'b0; start = 1'b0;
    checks++; if (ctl !== 4'b0000 || dig !== 16'h0002 || digit_cnt !== 3'd1) begin errors++; $display("FAIL coincide got %b/%h/%0d exp 0000/0002/1", ctl, dig, digit_cnt); end
    tick();
    press(4'd8);
    checks++; if (ctl !== 4'b1100 || dig !== 16'h0002 || digit_cnt !== 3'd1) begin errors++; $display("FAIL run_key got %b/%h/%0d exp 1100/0002/1", ctl, dig, digit_cnt); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL run_start got %b exp %b", ctl, 4'b1100); end
    clear = 1'b1; timer_zero = 1'b1; tick(); clear = 1'b0; timer_zero = 1'b0;
    checks++; if (ctl !== 4'b1000 || dig !== 16'h0000 || digit_cnt !== 3'd0) begin errors++; $display("FAIL clear_tz got %b/%h/%0d exp 1000/0000/0", ctl, dig, digit_cnt); end
    tick();
    checks++; if (ctl !== 4'b1000) begin errors++; $display("FAIL clear_tz_idle got %b exp %b", ctl, 4'b1000); end
  endtask

  task automatic test_reset_in_load();
    press(4'd4);
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL rl_load got %b exp %b", ctl, 4'b0000); end
    clrn = 1'b0; clear = 1'b1; tick(); clrn = 1'b1; clear = 1'b0;
    checks++; if (ctl !== 4'b1000 || dig !== 16'h0000 || digit_cnt !== 3'd0) begin errors++; $display("FAIL rl_abort got %b/%h/%0d exp 1000/0000/0", ctl, dig, digit_cnt); end
    tick();
    checks++; if (ctl !== 4'b1000) begin errors++; $display("FAIL rl_after got %b exp %b", ctl, 4'b1000); end
  endtask

  initial begin
    clrn = 1'b0; key_valid = 1'b0; key_code = 4'd0;
    start = 1'b0; clear = 1'b0; timer_zero = 1'b0;
    test_reset();
    test_entry_run();
    test_overflow();
    test_invalid_key();
    test_bad_start();
    test_coincide_and_run();
    test_reset_in_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
